// File: rtl/iomem_wb_bridge_if.sv
// Signal bundle between the PicoSoC iomem port, the bridge and the attached
// Wishbone slaves. The slave modport is the bridge's view; master is the
// view of the surrounding system (CPU request side plus the slaves' returns).
interface iomem_wb_bridge_if #(
    parameter int unsigned NUM_SLAVES = 4
);
    // iomem request/response
    logic                       iomem_valid;
    logic                       iomem_ready;
    logic [3:0]                 iomem_wstrb;
    logic [31:0]                iomem_addr;
    logic [31:0]                iomem_wdata;
    logic [31:0]                iomem_rdata;

    // shared Wishbone master signals
    logic [31:0]                wbm_adr_o;
    logic [31:0]                wbm_dat_o;
    logic                       wbm_we_o;
    logic [3:0]                 wbm_sel_o;

    // per-slave Wishbone signals
    logic [NUM_SLAVES-1:0]      wbs_cyc_o;
    logic [NUM_SLAVES-1:0]      wbs_stb_o;
    logic [NUM_SLAVES-1:0]      wbs_ack_i;
    logic [32*NUM_SLAVES-1:0]   wbs_dat_i;

    // status
    logic                       timeout_o;
    logic [7:0]                 err_count_o;

    modport slave (
        input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        input  wbs_ack_i, wbs_dat_i,
        output iomem_ready, iomem_rdata,
        output wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_sel_o,
        output wbs_cyc_o, wbs_stb_o,
        output timeout_o, err_count_o
    );

    modport master (
        output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        output wbs_ack_i, wbs_dat_i,
        input  iomem_ready, iomem_rdata,
        input  wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_sel_o,
        input  wbs_cyc_o, wbs_stb_o,
        input  timeout_o, err_count_o
    );
endinterface

// File: rtl/iomem_wb_bridge.sv
// PicoSoC iomem to classic Wishbone bridge with multi-slave decode.
// Requests inside the configured region are routed to one of NUM_SLAVES
// targets selected by an address field; unmapped slots and slaves that never
// ack get an error response (ERR_DATA) and bump a saturating error counter.
// All outputs are registered; only one transaction is ever outstanding.
module iomem_wb_bridge #(
    parameter int unsigned NUM_SLAVES     = 4,
    parameter logic [31:0] BASE_ADDR      = 32'h0300_0000,
    parameter logic [31:0] REGION_MASK    = 32'hFF00_0000,
    parameter int unsigned SEL_LSB        = 20,
    parameter int unsigned SLAVE_BITS     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic             clk,
    input  logic             reset,
    iomem_wb_bridge_if.slave bus
);

    localparam int unsigned TMR_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RESP
    } state_t;

    // registered state and outputs
    state_t                  state_q,   state_d;
    logic [31:0]             adr_q,     adr_d;
    logic [31:0]             dat_q,     dat_d;
    logic                    we_q,      we_d;
    logic [3:0]              sel_q,     sel_d;
    logic [NUM_SLAVES-1:0]   slv_q,     slv_d;
    logic                    ready_q,   ready_d;
    logic [31:0]             rdata_q,   rdata_d;
    logic                    timeout_q, timeout_d;
    logic [7:0]              err_q,     err_d;
    logic [TMR_W-1:0]        timer_q,   timer_d;

    // request decode and response mux
    logic                    region_hit;
    logic [SLAVE_BITS-1:0]   req_idx;
    logic                    idx_mapped;
    logic [NUM_SLAVES-1:0]   req_onehot;
    logic                    ack_hit;
    logic [31:0]             ack_data;
    logic [7:0]              err_inc;

    // Decode the incoming request and select the active slave's ack/data.
    // The active slave is held as a one-hot mask so non-selected acks are
    // masked out without needing an index wider than the slave count.
    always_comb begin
        region_hit = (bus.iomem_addr & REGION_MASK) == BASE_ADDR;
        req_idx    = bus.iomem_addr[SEL_LSB +: SLAVE_BITS];
        idx_mapped = {1'b0, req_idx} < (SLAVE_BITS + 1)'(NUM_SLAVES);
        req_onehot = '0;
        for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
            req_onehot[k] = (req_idx == SLAVE_BITS'(k));
        end
        ack_hit  = |(bus.wbs_ack_i & slv_q);
        ack_data = '0;
        for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
            if (slv_q[k]) begin
                ack_data = ack_data | bus.wbs_dat_i[32*k +: 32];
            end
        end
        err_inc = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
    end

    // Next-state and next-output computation for the IDLE/BUS/RESP machine.
    always_comb begin
        state_d   = state_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        we_d      = we_q;
        sel_d     = sel_q;
        slv_d     = slv_q;
        ready_d   = 1'b0;
        rdata_d   = rdata_q;
        timeout_d = 1'b0;
        err_d     = err_q;
        timer_d   = timer_q;

        case (state_q)
            IDLE: begin
                if (bus.iomem_valid && region_hit) begin
                    if (idx_mapped) begin
                        adr_d   = bus.iomem_addr;
                        dat_d   = bus.iomem_wdata;
                        we_d    = |bus.iomem_wstrb;
                        sel_d   = (|bus.iomem_wstrb) ? bus.iomem_wstrb : 4'hF;
                        slv_d   = req_onehot;
                        timer_d = TMR_W'(1);
                        state_d = BUS;
                    end else begin
                        ready_d = 1'b1;
                        rdata_d = ERR_DATA;
                        err_d   = err_inc;
                        state_d = RESP;
                    end
                end
            end

            BUS: begin
                // ack is tested first so an ack in the final timer cycle wins
                if (ack_hit) begin
                    slv_d   = '0;
                    we_d    = 1'b0;
                    rdata_d = ack_data;
                    ready_d = 1'b1;
                    state_d = RESP;
                end else if ((TIMEOUT_CYCLES != 0) && (timer_q == TMR_LIMIT)) begin
                    slv_d     = '0;
                    we_d      = 1'b0;
                    rdata_d   = ERR_DATA;
                    ready_d   = 1'b1;
                    timeout_d = 1'b1;
                    err_d     = err_inc;
                    state_d   = RESP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            RESP: begin
                // valid is deliberately not looked at here
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            adr_q     <= '0;
            dat_q     <= '0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            slv_q     <= '0;
            ready_q   <= 1'b0;
            rdata_q   <= '0;
            timeout_q <= 1'b0;
            err_q     <= '0;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            slv_q     <= slv_d;
            ready_q   <= ready_d;
            rdata_q   <= rdata_d;
            timeout_q <= timeout_d;
            err_q     <= err_d;
            timer_q   <= timer_d;
        end
    end

    assign bus.iomem_ready = ready_q;
    assign bus.iomem_rdata = rdata_q;
    assign bus.wbm_adr_o   = adr_q;
    assign bus.wbm_dat_o   = dat_q;
    assign bus.wbm_we_o    = we_q;
    assign bus.wbm_sel_o   = sel_q;
    assign bus.wbs_cyc_o   = slv_q;
    assign bus.wbs_stb_o   = slv_q;
    assign bus.timeout_o   = timeout_q;
    assign bus.err_count_o = err_q;

endmodule
